ifetch_prefetch: RTL and testbench

//  Instruction-fetch front end of risc_v_cpu. Generates sequential PCs, issues word reads
//  to instruction memory, buffers in-order responses in a small prefetch FIFO and hands
//  {pc, instr} pairs to decode over a valid/ready handshake.
//  A branch/jump redirect from execute flushes buffered and in-flight fetches.

---
 rtl/ifetch_prefetch.sv | 121 ++++++++++++
 tb/tb_ifetch_prefetch.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_prefetch.sv
// Instruction-fetch front end: sequential PC generation, in-order imem requests,
// a small prefetch FIFO and a valid/ready hand-off of {pc, instr} to decode.
module ifetch_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int          AW        = $clog2(DEPTH);
  localparam int          CW        = AW + 1;
  localparam logic [CW:0] DEPTH_OCC = (CW + 1)'(DEPTH);
  localparam logic [31:0] START_PC  = {RESET_PC[31:2], 2'b00};

  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] pcq_head;
  logic [AW-1:0] pcq_tail;
  logic [31:0]   fifo_pc    [DEPTH];
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   pcq        [DEPTH];

  logic          req_fire;
  logic          push;
  logic          pop;
  logic [CW:0]   occupancy;
  logic [CW-1:0] inflight_next;

  // Buffered plus in-flight fetches never exceed DEPTH, so a response always has a slot.
  always_comb begin
    occupancy      = {1'b0, count} + {1'b0, inflight};
    imem_req_valid = !reset && !redirect_valid && (occupancy < DEPTH_OCC);
    req_fire       = imem_req_valid && imem_req_ready;
    out_valid      = !reset && !redirect_valid && (count != '0);
    pop            = out_valid && out_ready;
    push           = imem_resp_valid && (drop == '0) && !redirect_valid;
    inflight_next  = inflight + CW'(req_fire) - CW'(imem_resp_valid);
  end

  assign imem_req_addr = fetch_pc;
  assign out_pc        = fifo_pc[head];
  assign out_instr     = fifo_instr[head];

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= START_PC;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
      head     <= '0;
      tail     <= '0;
      pcq_head <= '0;
      pcq_tail <= '0;
      // NOTE: FIFO storage is reset because out_pc/out_instr read it directly and must be 0 after reset.
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else begin
      inflight <= inflight_next;
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
        pcq_tail <= pcq_tail + AW'(1);
      end
      if (imem_resp_valid) begin
        pcq_head <= pcq_head + AW'(1);
      end
      if (redirect_valid) begin
        // Everything still outstanding after this cycle belongs to the old path.
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        count    <= '0;
        tail     <= head;
        drop     <= inflight_next;
      end else begin
        if (push) begin
          fifo_pc[tail]    <= pcq[pcq_head];
          fifo_instr[tail] <= imem_resp_data;
          tail             <= tail + AW'(1);
        end
        if (pop) begin
          head <= head + AW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
        if (imem_resp_valid && (drop != '0)) begin
          drop <= drop - CW'(1);
        end
      end
    end
  end

  // NOTE: the PC queue has no reset; its pointers are reset, so stale contents are never read.
  always_ff @(posedge clock) begin
    if (req_fire) begin
      pcq[pcq_tail] <= fetch_pc;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(push && !pop && (count == CW'(DEPTH))));
      assert (!(imem_resp_valid && (inflight == '0)));
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch: streaming, back-pressure, redirects, PC wrap, mid-stream reset.
module tb_ifetch_prefetch;

  logic        clock;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  logic        imem_req_valid2;
  logic [31:0] imem_req_addr2;
  logic        imem_resp_valid2;
  logic [31:0] imem_resp_data2;
  logic        out_valid2;
  logic [31:0] out_instr2;
  logic [31:0] out_pc2;

  int          tests_run;
  int          tests_failed;
  logic [31:0] exp_pc;
  logic [31:0] cyc;
  logic [31:0] lat;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] due;
  } mreq_t;
  mreq_t mq[$];

  logic        fire2;
  logic [31:0] addr2_q;

  ifetch_prefetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  ifetch_prefetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid2),
    .imem_req_ready (1'b1),
    .imem_req_addr  (imem_req_addr2),
    .imem_resp_valid(imem_resp_valid2),
    .imem_resp_data (imem_resp_data2),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0000_0000),
    .out_valid      (out_valid2),
    .out_ready      (1'b1),
    .out_instr      (out_instr2),
    .out_pc         (out_pc2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5EED_C0DE) + {a[15:0], a[31:16]};
  endfunction

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Instruction memory for dut: in-order, latency lat, flushed by the shared reset.
  initial begin
    cyc             = '0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(posedge clock);
      cyc = cyc + 1;
      #1;
      if (mq.size() != 0 && mq[0].due <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
      end
      @(negedge clock);
      if (reset) mq.delete();
      else if (imem_req_valid && imem_req_ready) mq.push_back('{addr: imem_req_addr, due: cyc + lat});
    end
  end

  // Latency-1 memory for dut_wrap.
  initial begin
    fire2            = 1'b0;
    addr2_q          = '0;
    imem_resp_valid2 = 1'b0;
    imem_resp_data2  = '0;
    forever begin
      @(posedge clock);
      #1;
      imem_resp_valid2 = fire2;
      imem_resp_data2  = mem_word(addr2_q);
      @(negedge clock);
      fire2   = !reset && imem_req_valid2;
      addr2_q = imem_req_addr2;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    next_cycle();
    next_cycle();
    @(negedge clock);
    tests_run++;
    if ({imem_req_valid, out_valid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_valids: got %b want 00", {imem_req_valid, out_valid});
    end
    tests_run++;
    if ({out_pc, out_instr} !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_out: got pc %h instr %h want 0 0", out_pc, out_instr);
    end
    tests_run++;
    if (imem_req_addr !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_addr: got %h want 00000000", imem_req_addr);
    end
    tests_run++;
    if ({out_valid2, imem_req_addr2} !== {1'b0, 32'hFFFF_FFF8}) begin
      tests_failed++;
      $display("FAIL reset_addr_wrap: got v%b %h want v0 fffffff8", out_valid2, imem_req_addr2);
    end
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] e;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (c == 0) begin
        tests_run++;
        if ({imem_req_valid, imem_req_addr, out_valid} !== {1'b1, 32'h0, 1'b0}) begin
          tests_failed++;
          $display("FAIL stream_first_req: got req %b addr %h out_valid %b want 1 0 0",
                   imem_req_valid, imem_req_addr, out_valid);
        end
      end else if (c == 1) begin
        tests_run++;
        if (out_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL stream_latency: out_valid got %b want 0 at cycle 1", out_valid);
        end
      end else begin
        e = 32'((c - 2) * 4);
        tests_run++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, e, mem_word(e)}) begin
          tests_failed++;
          $display("FAIL stream_out c%0d: got v%b pc %h instr %h want v1 pc %h instr %h",
                   c, out_valid, out_pc, out_instr, e, mem_word(e));
        end
      end
      next_cycle();
    end
    exp_pc = 32'h20;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      tests_run++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, exp_pc, mem_word(exp_pc)}) begin
        tests_failed++;
        $display("FAIL stall_hold c%0d: got v%b pc %h instr %h want v1 pc %h",
                 c, out_valid, out_pc, out_instr, exp_pc);
      end
      if (c == 9) begin
        tests_run++;
        if (imem_req_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL stall_full: imem_req_valid got %b want 0", imem_req_valid);
        end
      end
      next_cycle();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      tests_run++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, exp_pc, mem_word(exp_pc)}) begin
        tests_failed++;
        $display("FAIL drain c%0d: got v%b pc %h instr %h want v1 pc %h",
                 c, out_valid, out_pc, out_instr, exp_pc);
      end
      exp_pc = exp_pc + 32'd4;
      next_cycle();
    end
  endtask

  task automatic test_redirect_inflight();
    lat = 32'd3;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      redirect_valid = (c == 3);
      redirect_pc    = 32'h0000_0103;
      @(negedge clock);
      if (c == 3) begin
        tests_run++;
        if ({imem_req_valid, out_valid} !== 2'b00) begin
          tests_failed++;
          $display("FAIL redir_cycle: got req %b out %b want 0 0", imem_req_valid, out_valid);
        end
      end else if (c == 4) begin
        tests_run++;
        if ({imem_req_valid, imem_req_addr, out_valid} !== {1'b1, 32'h100, 1'b0}) begin
          tests_failed++;
          $display("FAIL redir_new_req: got req %b addr %h out %b want 1 00000100 0",
                   imem_req_valid, imem_req_addr, out_valid);
        end
      end else if (c < 8) begin
        tests_run++;
        if (out_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL redir_stale c%0d: out_valid got %b pc %h want 0", c, out_valid, out_pc);
        end
      end else begin
        exp_pc = (c == 8) ? 32'h100 : 32'h104;
        tests_run++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, exp_pc, mem_word(exp_pc)}) begin
          tests_failed++;
          $display("FAIL redir_target c%0d: got v%b pc %h instr %h want v1 pc %h",
                   c, out_valid, out_pc, out_instr, exp_pc);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect_handshake();
    lat = 32'd1;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      redirect_valid = (c == 5);
      redirect_pc    = 32'h0000_0202;
      @(negedge clock);
      if (c == 4) begin
        tests_run++;
        if ({out_valid, out_pc} !== {1'b1, 32'h8}) begin
          tests_failed++;
          $display("FAIL hs_pre: got v%b pc %h want v1 00000008", out_valid, out_pc);
        end
      end else if (c == 5) begin
        tests_run++;
        if ({imem_req_valid, out_valid} !== 2'b00) begin
          tests_failed++;
          $display("FAIL hs_redir_cycle: got req %b out %b want 0 0", imem_req_valid, out_valid);
        end
      end else if (c == 6) begin
        tests_run++;
        if ({imem_req_valid, imem_req_addr, out_valid} !== {1'b1, 32'h200, 1'b0}) begin
          tests_failed++;
          $display("FAIL hs_new_req: got req %b addr %h out %b want 1 00000200 0",
                   imem_req_valid, imem_req_addr, out_valid);
        end
      end else if (c == 7) begin
        tests_run++;
        if (out_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL hs_dropped: out_valid got %b pc %h want 0", out_valid, out_pc);
        end
      end else if (c >= 8) begin
        exp_pc = (c == 8) ? 32'h200 : 32'h204;
        tests_run++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, exp_pc, mem_word(exp_pc)}) begin
          tests_failed++;
          $display("FAIL hs_target c%0d: got v%b pc %h instr %h want v1 pc %h",
                   c, out_valid, out_pc, out_instr, exp_pc);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_pc_wrap();
    logic [31:0] e;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (c == 0) begin
        tests_run++;
        if ({imem_req_valid2, imem_req_addr2} !== {1'b1, 32'hFFFF_FFF8}) begin
          tests_failed++;
          $display("FAIL wrap_first_req: got %b %h want 1 fffffff8", imem_req_valid2, imem_req_addr2);
        end
      end else if (c >= 2) begin
        e = 32'hFFFF_FFF8 + 32'((c - 2) * 4);
        tests_run++;
        if ({out_valid2, out_pc2, out_instr2} !== {1'b1, e, mem_word(e)}) begin
          tests_failed++;
          $display("FAIL wrap_out c%0d: got v%b pc %h instr %h want v1 pc %h",
                   c, out_valid2, out_pc2, out_instr2, e);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    repeat (8) next_cycle();
    @(negedge clock);
    tests_run++;
    if ({imem_req_valid, out_valid} !== 2'b01) begin
      tests_failed++;
      $display("FAIL mid_full: got req %b out %b want 0 1", imem_req_valid, out_valid);
    end
    next_cycle();
    reset     = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    tests_run++;
    if ({imem_req_valid, out_valid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL mid_reset_cycle: got req %b out %b want 0 0", imem_req_valid, out_valid);
    end
    next_cycle();
    @(negedge clock);
    tests_run++;
    if ({imem_req_valid, out_valid, out_pc, out_instr, imem_req_addr} !== 98'h0) begin
      tests_failed++;
      $display("FAIL mid_reset_state: got req %b out %b pc %h instr %h addr %h want all 0",
               imem_req_valid, out_valid, out_pc, out_instr, imem_req_addr);
    end
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (c == 0) begin
        tests_run++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
          tests_failed++;
          $display("FAIL mid_refetch: got %b %h want 1 00000000", imem_req_valid, imem_req_addr);
        end
      end else if (c >= 2) begin
        exp_pc = 32'((c - 2) * 4);
        tests_run++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, exp_pc, mem_word(exp_pc)}) begin
          tests_failed++;
          $display("FAIL mid_restream c%0d: got v%b pc %h instr %h want v1 pc %h",
                   c, out_valid, out_pc, out_instr, exp_pc);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    exp_pc         = '0;
    lat            = 32'd1;
    reset          = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;

    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_handshake();
    test_reset_pc_wrap();
    test_mid_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
